// File: rtl/spi_memory_burst_if.sv
// Pin-side bundle of the SPI burst memory: raw SPI pins in, registered SPI
// outputs plus status/debug out. The bus master drives the pins.
interface spi_memory_burst_if #(
    parameter int ADDR_WIDTH = 7
);
    // frame_done is a single-clk pulse per completed data frame. miso_pin is
    // only meaningful while miso_en is high. There is no backpressure.
    logic                  sclk_pin;
    logic                  cs_pin;
    logic                  mosi_pin;
    logic                  miso_pin;
    logic                  miso_en;
    logic                  busy;
    logic                  frame_done;
    logic [ADDR_WIDTH-1:0] addr_out;
    logic [1:0]            state_dbg;

    modport master (
        output sclk_pin, cs_pin, mosi_pin,
        input  miso_pin, miso_en, busy, frame_done, addr_out, state_dbg
    );

    modport slave (
        input  sclk_pin, cs_pin, mosi_pin,
        output miso_pin, miso_en, busy, frame_done, addr_out, state_dbg
    );
endinterface

// File: rtl/spi_memory_burst.sv
// SPI mode-0 slave memory: address/R-W header followed by a burst of data
// frames, auto-incrementing address that wraps at the top of memory.
module spi_memory_burst #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_memory_burst_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    // rx only needs to hold the bits preceding the final one of either frame.
    localparam int RXW   = (ADDR_WIDTH > DATA_WIDTH - 1) ? ADDR_WIDTH : DATA_WIDTH - 1;
    localparam int CW    = $clog2(RXW + 1);

    typedef enum logic [1:0] {IDLE, HEADER, WRITE, READ} state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_d, cs_d, mosi_d;
    logic                   sclk_pos, sclk_neg, cs_fall, cs_rise, mosi_s;

    logic [CW-1:0]          bit_cnt;
    logic [RXW-1:0]         rx;
    logic [DATA_WIDTH-1:0]  tx;
    logic [ADDR_WIDTH-1:0]  addr, addr_inc;
    logic                   miso_r, miso_en_r, frame_done_r, rd_load;
    logic                   hdr_done, wr_done, rd_done;

    logic [DATA_WIDTH-1:0]  mem [DEPTH];

    // cs chain resets low so a pin already low after reset gives no cs_fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b0;
            mosi_d    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk_pin};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs_pin};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi_pin};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            cs_d      <= cs_sync[SYNC_STAGES-1];
            mosi_d    <= mosi_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_pos = sclk_sync[SYNC_STAGES-1] & ~sclk_d;
    assign sclk_neg = ~sclk_sync[SYNC_STAGES-1] & sclk_d;
    assign cs_fall  = ~cs_sync[SYNC_STAGES-1] & cs_d;
    assign cs_rise  = cs_sync[SYNC_STAGES-1] & ~cs_d;
    assign mosi_s   = mosi_d;
    assign addr_inc = addr + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // A frame-completing sclk_pos is still honoured when cs_rise lands with it.
    always_comb begin
        state_next = state;
        hdr_done   = 1'b0;
        wr_done    = 1'b0;
        rd_done    = 1'b0;
        case (state)
            IDLE:   if (cs_fall) state_next = HEADER;
            HEADER: if (sclk_pos && bit_cnt == CW'(ADDR_WIDTH)) begin
                        hdr_done   = 1'b1;
                        state_next = mosi_s ? READ : WRITE;
                    end
            WRITE:  wr_done = sclk_pos && (bit_cnt == CW'(DATA_WIDTH - 1));
            READ:   rd_done = sclk_pos && (bit_cnt == CW'(DATA_WIDTH - 1));
            default: state_next = IDLE;
        endcase
        if (cs_rise) state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt      <= '0;
            rx           <= '0;
            tx           <= '0;
            addr         <= '0;
            miso_r       <= 1'b0;
            miso_en_r    <= 1'b0;
            frame_done_r <= 1'b0;
            rd_load      <= 1'b0;
        end else begin
            frame_done_r <= wr_done | rd_done;
            rd_load      <= hdr_done & mosi_s & ~cs_rise;

            if (state == IDLE) begin
                if (cs_fall) begin
                    bit_cnt <= '0;
                    rx      <= '0;
                end
            end else if (sclk_pos) begin
                rx <= {rx[RXW-2:0], mosi_s};
                if (hdr_done || wr_done || rd_done) bit_cnt <= '0;
                else                                bit_cnt <= bit_cnt + 1'b1;
            end

            if (hdr_done)               addr <= rx[ADDR_WIDTH-1:0];
            else if (wr_done || rd_done) addr <= addr_inc;

            // The reload lands before the next sclk_neg, so bursts are gapless.
            if (rd_load) begin
                tx        <= mem[addr];
                miso_en_r <= 1'b1;
            end else if (rd_done) begin
                tx <= mem[addr_inc];
            end else if (state == READ && sclk_neg) begin
                miso_r <= tx[DATA_WIDTH-1];
                tx     <= {tx[DATA_WIDTH-2:0], 1'b0};
            end

            if (cs_rise) begin
                bit_cnt   <= '0;
                miso_en_r <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_done) mem[addr] <= {rx[DATA_WIDTH-2:0], mosi_s};
    end

    assign bus.miso_pin   = miso_r;
    assign bus.miso_en    = miso_en_r;
    assign bus.busy       = (state != IDLE);
    assign bus.frame_done = frame_done_r;
    assign bus.addr_out   = addr;
    assign bus.state_dbg  = state;
endmodule

// File: tb/tb_spi_memory_burst.sv
// Bench for spi_memory_burst: an SPI master driver, an array memory model,
// and two monitors (frame_done/address and MISO bytes) fed by expected queues.
module tb_spi_memory_burst;
    localparam int DW    = 8;
    localparam int AW    = 7;
    localparam int SS    = 2;
    localparam int HALF  = 8;
    localparam int DEPTH = 1 << AW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    spi_memory_burst_if #(.ADDR_WIDTH(AW)) bus ();

    spi_memory_burst #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .SYNC_STAGES(SS)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] exp_fd_q[$];
    logic [DW-1:0] model_mem[DEPTH];
    logic [DW-1:0] wbuf[4];
    logic [DW-1:0] rd_sh;
    int            rd_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Every frame_done must match a frame the driver issued, with the address
    // already advanced past that frame.
    always @(negedge clk) begin
        if (rst_n && bus.frame_done) begin
            if (exp_fd_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL frame_done_unexpected: got pulse at addr 0x%0h expected none", bus.addr_out);
            end else begin
                logic [AW-1:0] ea;
                ea = exp_fd_q.pop_front();
                check("frame_done_addr", 32'(bus.addr_out), 32'(ea));
            end
        end
    end

    // Master-side view of MISO: sample on sclk rise while miso_en is high.
    always @(posedge bus.sclk_pin or posedge bus.cs_pin or negedge rst_n) begin
        if (!rst_n || bus.cs_pin) begin
            rd_cnt = 0;
        end else if (bus.miso_en) begin
            rd_sh = {rd_sh[DW-2:0], bus.miso_pin};
            rd_cnt++;
            if (rd_cnt == DW) begin
                rd_cnt = 0;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL read_unexpected: got 0x%0h expected no byte", rd_sh);
                end else begin
                    logic [DW-1:0] ed;
                    ed = exp_q.pop_front();
                    check("read_data", 32'(rd_sh), 32'(ed));
                end
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_bit(input logic b);
        bus.mosi_pin = b;
        wait_clk(HALF);
        bus.sclk_pin = 1'b1;
        wait_clk(HALF);
        bus.sclk_pin = 1'b0;
    endtask

    task automatic send_header(input logic [AW-1:0] a, input logic rw);
        for (int i = AW - 1; i >= 0; i--) spi_bit(a[i]);
        spi_bit(rw);
    endtask

    task automatic cs_start();
        bus.cs_pin = 1'b0;
        wait_clk(HALF);
    endtask

    // Raise cs, confirm the block went idle, then hold cs high for the rest
    // of one sclk period while watching miso_en.
    task automatic cs_stop(input logic [AW-1:0] exp_addr);
        logic bad;
        wait_clk(HALF);
        bus.cs_pin = 1'b1;
        wait_clk(SS + 2);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_miso_en", 32'(bus.miso_en), 32'd0);
        check("idle_addr_out", 32'(bus.addr_out), 32'(exp_addr));
        bad = 1'b0;
        repeat (2 * HALF - SS - 2) begin
            wait_clk(1);
            if (bus.miso_en !== 1'b0) bad = 1'b1;
        end
        check("gap_miso_en", 32'(bad), 32'd0);
    endtask

    task automatic write_burst(input logic [AW-1:0] a, input int n);
        logic [AW-1:0] ak;
        cs_start();
        send_header(a, 1'b0);
        for (int k = 0; k < n; k++) begin
            ak = a + AW'(k);
            model_mem[ak] = wbuf[k];
            exp_fd_q.push_back(ak + 1'b1);
            for (int i = DW - 1; i >= 0; i--) spi_bit(wbuf[k][i]);
        end
        cs_stop(a + AW'(n));
    endtask

    task automatic read_burst(input logic [AW-1:0] a, input int n);
        logic [AW-1:0] ak;
        cs_start();
        send_header(a, 1'b1);
        for (int k = 0; k < n; k++) begin
            ak = a + AW'(k);
            exp_q.push_back(model_mem[ak]);
            exp_fd_q.push_back(ak + 1'b1);
            for (int i = 0; i < DW; i++) spi_bit(1'($urandom_range(0, 1)));
        end
        cs_stop(a + AW'(n));
    endtask

    initial begin
        #800000;
        checks++;
        failures++;
        $display("FAIL watchdog: got no finish within time budget expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        logic bad;
        logic [AW-1:0] ra;
        int n;

        bus.cs_pin   = 1'b1;
        bus.sclk_pin = 1'b0;
        bus.mosi_pin = 1'b0;
        wait_clk(3);
        check("rst_miso_pin", 32'(bus.miso_pin), 32'd0);
        check("rst_miso_en", 32'(bus.miso_en), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_frame_done", 32'(bus.frame_done), 32'd0);
        check("rst_addr_out", 32'(bus.addr_out), 32'd0);
        rst_n = 1'b1;
        wait_clk(SS + 4);

        // Write burst then, after a one-period gap, read it back.
        wbuf[0] = 8'hA5; wbuf[1] = 8'h3C; wbuf[2] = 8'hFF;
        write_burst(7'h05, 3);
        read_burst(7'h05, 3);

        // Address wrap at the top of memory.
        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        write_burst(7'h7F, 2);
        read_burst(7'h7F, 2);

        // Aborted write frame leaves memory untouched and pulses nothing.
        wbuf[0] = 8'h5A;
        write_burst(7'h10, 1);
        cs_start();
        send_header(7'h10, 1'b0);
        for (int i = 0; i < 5; i++) spi_bit(1'(i & 1));
        bus.cs_pin = 1'b1;
        wait_clk(SS + 2);
        check("abort_busy", 32'(bus.busy), 32'd0);
        wait_clk(2 * HALF);
        read_burst(7'h10, 1);

        // Reset during the third read bit.
        cs_start();
        send_header(7'h05, 1'b1);
        spi_bit(1'b0);
        spi_bit(1'b0);
        bus.mosi_pin = 1'b0;
        wait_clk(HALF);
        bus.sclk_pin = 1'b1;
        wait_clk(2);
        rst_n = 1'b0;
        #1;
        check("rstmid_miso_pin", 32'(bus.miso_pin), 32'd0);
        check("rstmid_miso_en", 32'(bus.miso_en), 32'd0);
        check("rstmid_addr_out", 32'(bus.addr_out), 32'd0);
        check("rstmid_busy", 32'(bus.busy), 32'd0);
        wait_clk(HALF);
        bus.sclk_pin = 1'b0;
        wait_clk(4);
        rst_n = 1'b1;
        // cs is still low: the block must wait for a fresh falling edge.
        bad = 1'b0;
        for (int i = 0; i < DW; i++) begin
            spi_bit(1'b1);
            if (bus.busy !== 1'b0) bad = 1'b1;
        end
        check("post_rst_idle", 32'(bad), 32'd0);
        bus.cs_pin = 1'b1;
        wait_clk(2 * HALF);
        read_burst(7'h05, 3);

        // Random write bursts, each read back from the model.
        for (int t = 0; t < 6; t++) begin
            ra = AW'($urandom_range(0, DEPTH - 1));
            n  = $urandom_range(1, 4);
            for (int k = 0; k < 4; k++) wbuf[k] = DW'($urandom_range(0, 255));
            write_burst(ra, n);
            read_burst(ra, n);
        end

        wait_clk(20);
        check("exp_read_drained", 32'(exp_q.size()), 32'd0);
        check("exp_frame_drained", 32'(exp_fd_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_memory_burst.md
# spi_memory_burst

Parametrised SPI-slave memory, the next generation of the team's SPI memory top. It synchronises the raw SPI pins, decodes an address/R-W header, and then runs a burst of data frames in either direction. The address auto-increments per frame and wraps at the top of memory. It sits between the board SPI pins and the LED/debug logic, and exports an enable so the pad-level tristate buffer remains external.

## Interface
- DATA_WIDTH, 8, bits per data frame and per memory word
- ADDR_WIDTH, 7, address bits; memory depth is 2**ADDR_WIDTH words
- SYNC_STAGES, 2, synchroniser flops per SPI input (minimum 2)
- clk  input  1  system clock; all logic is on its rising edge
- rst_n  input  1  reset, asynchronous and active-low; one clock, reset asynchronous active-low
- sclk_pin  input  1  raw SPI clock, asynchronous to clk
- cs_pin  input  1  raw chip select, active-low
- mosi_pin  input  1  raw master-out data
- miso_pin  output  1  registered master-in data
- miso_en  output  1  drive enable for the external tri_buff
- busy  output  1  high while a transaction is active (state not IDLE)
- frame_done  output  1  one-clk pulse per completed data frame
- addr_out  output  ADDR_WIDTH  current burst address (debug/LEDs)

## Operation
- Each pin passes through SYNC_STAGES flops plus one edge register, producing sclk_pos, sclk_neg, cs_fall, cs_rise and mosi_s.
- SPI mode 0:
  - Sample mosi_s on sclk_pos.
  - Update miso_pin on sclk_neg.
  - Bits travel MSB first.
- Header frame is ADDR_WIDTH+1 bits: address[ADDR_WIDTH-1:0], then R/W bit (1 = read, 0 = write).
- States:
  - IDLE: on cs_fall, go to HEADER.
  - HEADER: shift in ADDR_WIDTH+1 bits. On the last bit, latch the address into addr_out, then go to READ if R/W=1, otherwise WRITE.
  - WRITE: shift DATA_WIDTH bits into rx. On the last bit:
    - write mem[addr] <= rx
    - addr <= addr+1
    - pulse frame_done
    - stay in WRITE
  - READ: on entry, load tx <= mem[addr] and assert miso_en. Each sclk_neg shifts tx out via miso_pin. After DATA_WIDTH sclk_pos edges:
    - addr <= addr+1
    - reload tx <= mem[addr+1]
    - pulse frame_done
    - stay in READ
- Any state: cs_rise returns to IDLE, deasserts miso_en and clears the bit counter.
- Address arithmetic is modulo 2**ADDR_WIDTH: address 2**ADDR_WIDTH-1 increments to 0 with no flag.
- Memory is DEPTH x DATA_WIDTH with asynchronous read and synchronous write. rst_n does not clear memory contents.

## Timing
- Reset values:
  - miso_pin 0, miso_en 0, busy 0, frame_done 0, addr_out 0
  - state IDLE, bit counter 0, rx 0, tx 0
- Pin-to-edge-pulse latency is SYNC_STAGES+1 clk cycles.
- Required sclk high and low times are each ≥ SYNC_STAGES+3 clk cycles.
- Header completion: addr_out updates 1 clk after the final header sclk_pos pulse.
- Read entry:
  - tx loads and miso_en rises 2 clk after the final header sclk_pos pulse.
  - The first data MSB appears on miso_pin 1 clk after the next sclk_neg.
- Write commit: mem write and frame_done occur 1 clk after the final data sclk_pos pulse. addr increments in the same cycle.
- Read reload: tx reloads 1 clk after the final sclk_pos of a frame, before the following sclk_neg. This allows gapless bursts.
- cs_rise mid-frame: the partial write frame is discarded (no memory write) and the partial read frame is abandoned. miso_en goes low 1 clk after cs_rise.
- cs_rise in the same clk as a frame-completing sclk_pos: the frame completes first (write commits), then the block goes to IDLE.
- cs_fall while not IDLE is ignored.
- rst_n asserted mid-transaction: all outputs immediately take their reset values. After rst_n deassertion, the block waits for a fresh cs_fall, even if cs_pin is already low.

## Test plan
- Write burst: header addr=0x05, W; data 0xA5, 0x3C, 0xFF → mem[5]=A5, mem[6]=3C, mem[7]=FF, three frame_done pulses, addr_out=0x08 at cs_rise.
- Read burst: header addr=0x05, R, then 24 sclk cycles → miso yields A5, 3C, FF MSB-first, miso_en high only while cs is low.
- Wrap: write header addr=0x7F, data 0x11, 0x22 → mem[7F]=11, mem[00]=22, addr_out=0x01.
- Abort: write header addr=0x10 and 5 of 8 data bits, then cs high → mem[10] unchanged, no frame_done, busy=0 within SYNC_STAGES+2 clk.
- Reset mid-read: assert rst_n low during the 3rd read bit → miso_pin=0, miso_en=0, addr_out=0 immediately. A new transaction after release reads correct data.
- Idle/back-to-back: cs high for one sclk period between a write and a read transaction → both complete correctly, miso_en=0 throughout the gap.
